hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: a scoreboard of in-flight register writes that
// stalls decode, plus branch flushes and a HALT drain sequence.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic [2:0] dec_rs,
  input  logic [2:0] dec_rt,
  input  logic       dec_rs_used,
  input  logic       dec_rt_used,
  input  logic       dec_wr_en,
  input  logic [2:0] dec_wr_sel,
  input  logic       dec_halt,
  input  logic       branch_taken,
  output logic       pc_en,
  output logic       ftch_dec_en,
  output logic       ftch_dec_flush,
  output logic       dec_exe_bubble,
  output logic       exe_mem_en,
  output logic       mem_wb_en,
  output logic       halted,
  output logic       err
);

  localparam int unsigned REG_W    = 3;
  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned CNT_W    = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] sel;
  } sb_entry_t;

  state_e                         state_q, state_d;
  sb_entry_t [SB_DEPTH-1:0]       sb_q, sb_d;
  logic      [CNT_W-1:0]          drain_cnt_q, drain_cnt_d;
  logic      [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

  logic match_rs, match_rt;
  logic in_run, stall, issue;

  // Any in-flight writer (EXE/MEM/WB) targeting a decode source register.
  always_comb begin
    match_rs = 1'b0;
    match_rt = 1'b0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      if (sb_q[i].valid && (sb_q[i].sel == dec_rs)) match_rs = 1'b1;
      if (sb_q[i].valid && (sb_q[i].sel == dec_rt)) match_rt = 1'b1;
    end
  end

  assign in_run = (state_q == ST_RUN);
  assign stall  = in_run & dec_valid &
                  ((dec_rs_used & match_rs) | (dec_rt_used & match_rt));
  assign issue  = in_run & dec_valid & ~stall;

  // Next-state: scoreboard shift, counters and RUN/DRAIN/HALTED sequencing.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = '0;
    sb_d[0].valid = issue & dec_wr_en;
    sb_d[0].sel   = dec_wr_sel;
    for (int i = 1; i < int'(SB_DEPTH); i++) begin
      sb_d[i] = sb_q[i-1];
    end

    if (stall) begin
      stall_cnt_d = (stall_cnt_q == CNT_W'(3)) ? stall_cnt_q
                                               : stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (issue && dec_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = CNT_W'(3);
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - CNT_W'(1);
        // HALT reaches WB as the count runs out.
        if (drain_cnt_q <= CNT_W'(1)) begin
          state_d     = ST_HALTED;
          drain_cnt_d = '0;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      sb_q        <= '0;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Pipeline register controls follow state and stall directly.
  always_comb begin
    pc_en          = 1'b1;
    ftch_dec_en    = 1'b1;
    ftch_dec_flush = 1'b0;
    dec_exe_bubble = 1'b0;
    exe_mem_en     = 1'b1;
    mem_wb_en      = 1'b1;
    halted         = 1'b0;

    case (state_q)
      ST_HALTED: begin
        pc_en          = 1'b0;
        ftch_dec_en    = 1'b0;
        exe_mem_en     = 1'b0;
        mem_wb_en      = 1'b0;
        dec_exe_bubble = 1'b1;
        halted         = 1'b1;
      end
      ST_DRAIN: begin
        pc_en          = 1'b0;
        ftch_dec_en    = 1'b0;
        dec_exe_bubble = 1'b1;
      end
      default: begin
        if (stall) begin
          pc_en          = 1'b0;
          ftch_dec_en    = 1'b0;
          dec_exe_bubble = 1'b1;
        end else if (dec_valid && branch_taken) begin
          ftch_dec_flush = 1'b1;
        end
      end
    endcase
  end

  assign err = (stall & (stall_cnt_q == CNT_W'(3))) |
               (dec_valid & dec_halt & branch_taken);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: timestamped write-history model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid, dec_rs_used, dec_rt_used, dec_wr_en, dec_halt, branch_taken;
  logic [2:0] dec_rs, dec_rt, dec_wr_sel;
  logic       pc_en, ftch_dec_en, ftch_dec_flush, dec_exe_bubble;
  logic       exe_mem_en, mem_wb_en, halted, err;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .dec_wr_en(dec_wr_en), .dec_wr_sel(dec_wr_sel),
    .dec_halt(dec_halt), .branch_taken(branch_taken),
    .pc_en(pc_en), .ftch_dec_en(ftch_dec_en), .ftch_dec_flush(ftch_dec_flush),
    .dec_exe_bubble(dec_exe_bubble), .exe_mem_en(exe_mem_en),
    .mem_wb_en(mem_wb_en), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: writes issued at cycle t are visible to readers for cycles t+1..t+3.
  typedef struct {
    int         t;
    logic [2:0] sel;
  } wr_rec_t;

  wr_rec_t wq[$];
  int      cyc    = 0;
  int      halt_t = -1;
  int      streak = 0;

  logic s_pc, s_fd, s_fl, s_bub, s_em, s_mw, s_h, s_err;

  function automatic bit m_pending(input logic [2:0] r);
    foreach (wq[i]) begin
      if ((cyc - wq[i].t) <= 3 && wq[i].sel == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    wq.delete();
    halt_t = -1;
    streak = 0;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive decode, compare all outputs at negedge, advance model.
  task automatic step(input logic dv, input logic [2:0] rs, input logic [2:0] rt,
                      input logic rsu, input logic rtu, input logic wr,
                      input logic [2:0] ws, input logic dh, input logic bt);
    bit run, drn, hlt, st;
    logic e_pc, e_fd, e_fl, e_bub, e_em, e_mw, e_h, e_err;
    dec_valid = dv; dec_rs = rs; dec_rt = rt; dec_rs_used = rsu; dec_rt_used = rtu;
    dec_wr_en = wr; dec_wr_sel = ws; dec_halt = dh; branch_taken = bt;
    @(negedge clk);
    if (rst) model_reset();
    run = (halt_t < 0);
    hlt = !run && (cyc - halt_t >= 4);
    drn = !run && !hlt;
    st  = run && dv && ((rsu && m_pending(rs)) || (rtu && m_pending(rt)));

    e_pc = 1; e_fd = 1; e_fl = 0; e_bub = 0; e_em = 1; e_mw = 1; e_h = 0;
    if (hlt) begin
      e_pc = 0; e_fd = 0; e_em = 0; e_mw = 0; e_bub = 1; e_h = 1;
    end else if (drn || st) begin
      e_pc = 0; e_fd = 0; e_bub = 1;
    end else if (dv && bt) begin
      e_fl = 1;
    end
    e_err = (st && streak >= 3) || (dv && dh && bt);

    chk("pc_en", pc_en, e_pc);
    chk("ftch_dec_en", ftch_dec_en, e_fd);
    chk("ftch_dec_flush", ftch_dec_flush, e_fl);
    chk("dec_exe_bubble", dec_exe_bubble, e_bub);
    chk("exe_mem_en", exe_mem_en, e_em);
    chk("mem_wb_en", mem_wb_en, e_mw);
    chk("halted", halted, e_h);
    chk("err", err, e_err);
    s_pc = pc_en; s_fd = ftch_dec_en; s_fl = ftch_dec_flush; s_bub = dec_exe_bubble;
    s_em = exe_mem_en; s_mw = mem_wb_en; s_h = halted; s_err = err;

    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (run && dv && !st) begin
        if (wr) wq.push_back('{t: cyc, sel: ws});
        if (dh) halt_t = cyc;
      end
      streak = st ? ((streak < 3) ? streak + 1 : 3) : 0;
    end
    while (wq.size() > 0 && (cyc - wq[0].t) >= 3) void'(wq.pop_front());
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rs_used = 0; dec_rt_used = 0;
    dec_wr_en = 0; dec_wr_sel = 0; dec_halt = 0; branch_taken = 0;
    @(posedge clk); #1;

    // Reset values with rst held high
    idle();
    chk("rst_pc_en", s_pc, 1'b1);
    chk("rst_exe_mem_en", s_em, 1'b1);
    chk("rst_bubble", s_bub, 1'b0);
    chk("rst_halted", s_h, 1'b0);
    rst = 1'b0;
    idle();

    // Back-to-back RAW: writer r3 then reader of r3 stalls three cycles
    step(1, 3'd0, 3'd0, 0, 0, 1, 3'd3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3'd3, 3'd1, 1, 0, 0, 3'd0, 0, 0);
      chk("raw3_pc_en", s_pc, 1'b0);
      chk("raw3_bubble", s_bub, 1'b1);
      chk("raw3_err", s_err, 1'b0);
    end
    step(1, 3'd3, 3'd1, 1, 0, 0, 3'd0, 0, 0);
    chk("raw3_issue_pc_en", s_pc, 1'b1);
    chk("raw3_issue_bubble", s_bub, 1'b0);

    // Writer r2, two independent, then reader: one stall cycle (WB match)
    step(1, 3'd0, 3'd0, 0, 0, 1, 3'd2, 0, 0);
    step(1, 3'd0, 3'd1, 1, 1, 0, 3'd0, 0, 0);
    step(1, 3'd4, 3'd5, 1, 1, 0, 3'd0, 0, 0);
    step(1, 3'd7, 3'd2, 0, 1, 0, 3'd0, 0, 0);
    chk("raw1_stall_pc_en", s_pc, 1'b0);
    step(1, 3'd7, 3'd2, 0, 1, 0, 3'd0, 0, 0);
    chk("raw1_issue_pc_en", s_pc, 1'b1);

    // Branch without dependency flushes immediately
    step(1, 3'd4, 3'd0, 1, 0, 0, 3'd0, 0, 1);
    chk("br_flush", s_fl, 1'b1);
    chk("br_pc_en", s_pc, 1'b1);
    idle();
    chk("br_flush_clear", s_fl, 1'b0);

    // Branch reading r6 right after its writer: flush deferred past the stall
    step(1, 3'd0, 3'd0, 0, 0, 1, 3'd6, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3'd6, 3'd0, 1, 0, 0, 3'd0, 0, 1);
      chk("brdep_no_flush", s_fl, 1'b0);
    end
    step(1, 3'd6, 3'd0, 1, 0, 0, 3'd0, 0, 1);
    chk("brdep_flush", s_fl, 1'b1);

    // HALT: drain three cycles, halted from the fourth, held for 20 cycles
    step(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0);
    chk("halt_issue_pc_en", s_pc, 1'b1);
    for (int i = 1; i <= 23; i++) begin
      step(i[0], 3'd1, 3'd2, 1, 1, 1, 3'd1, 0, 0);
      if (i == 1) chk("halt_next_pc_en", s_pc, 1'b0);
      if (i == 3) chk("halt_drain_end", s_h, 1'b0);
      if (i >= 4) chk("halt_held", s_h, 1'b1);
    end
    rst_cycle();

    // HALT with simultaneous branch still drains and raises err
    step(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 1);
    chk("halt_br_err", s_err, 1'b1);
    idle();
    chk("halt_br_drain_pc_en", s_pc, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    chk("halt_br_halted", s_h, 1'b1);
    rst_cycle();

    // Reset mid-DRAIN clears state and scoreboard at once
    step(1, 3'd0, 3'd0, 0, 0, 1, 3'd5, 1, 0);
    idle();
    rst = 1'b1;
    idle();
    chk("drain_rst_halted", s_h, 1'b0);
    chk("drain_rst_pc_en", s_pc, 1'b1);
    rst = 1'b0;
    step(1, 3'd5, 3'd5, 1, 1, 0, 3'd0, 0, 0);
    chk("drain_rst_reader_pc_en", s_pc, 1'b1);
    chk("drain_rst_reader_bubble", s_bub, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic dv, rsu, rtu, wr, dh, bt;
      logic [2:0] rs, rt, ws;
      dv  = ($urandom % 4) != 0;
      rs  = 3'($urandom % 8);
      rt  = 3'($urandom % 8);
      rsu = ($urandom % 3) != 0;
      rtu = ($urandom % 2) != 0;
      wr  = ($urandom % 3) != 0;
      ws  = 3'($urandom % 8);
      dh  = ($urandom % 40) == 0;
      bt  = ($urandom % 8) == 0;
      if ((halt_t >= 0 && (cyc - halt_t) >= 9) || ($urandom % 200) == 0) rst = 1'b1;
      step(dv, rs, rt, rsu, rtu, wr, ws, dh, bt);
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
